// File: rtl/axis_accumulator_pkg.sv
// Shared types and constant helpers for the packet accumulator and the
// requantisation stages built on top of it.
package axis_accumulator_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    // True when a half-LSB bias must be added before the arithmetic shift.
    function automatic bit round_active(input int shift, input int round_enable);
        return (round_enable != 0) && (shift > 0);
    endfunction

    // Bit position of the half-LSB bias; clamped so SHIFT=0 stays legal.
    function automatic int round_pos(input int shift);
        return (shift > 0) ? (shift - 1) : 0;
    endfunction

endpackage

// File: rtl/axis_accumulator_sat_round_shift.sv
// Combinational round-half-up, arithmetic right shift and signed saturation
// from IN_W to OUT_W bits; sat flags a clamped result.
module axis_accumulator_sat_round_shift
    import axis_accumulator_pkg::*;
#(
    parameter int IN_W         = 40,
    parameter int OUT_W        = 16,
    parameter int SHIFT        = 0,
    parameter int ROUND_ENABLE = 1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    localparam int HEAD_W = IN_W - OUT_W + 2;

    // One extra bit of headroom means the bias can never overflow the add.
    localparam logic signed [IN_W:0] BIAS =
        round_active(SHIFT, ROUND_ENABLE) ? ({{IN_W{1'b0}}, 1'b1} << round_pos(SHIFT))
                                          : {(IN_W+1){1'b0}};

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0]   biased_s;
    logic signed [IN_W:0]   shifted_s;
    logic [HEAD_W-1:0]      head_s;

    // Bias, shift, then clamp whenever the bits above the output sign disagree.
    always_comb begin
        biased_s  = {din[IN_W-1], din} + BIAS;
        shifted_s = biased_s >>> SHIFT;
        head_s    = shifted_s[IN_W:OUT_W-1];
        dout      = shifted_s[OUT_W-1:0];
        sat       = 1'b0;
        if ((head_s == {HEAD_W{1'b0}}) || (head_s == {HEAD_W{1'b1}})) begin
            dout = shifted_s[OUT_W-1:0];
            sat  = 1'b0;
        end else if (head_s[HEAD_W-1]) begin
            dout = OUT_MIN;
            sat  = 1'b1;
        end else begin
            dout = OUT_MAX;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/axis_accumulator.sv
// Packet-wise AXI-Stream accumulator: sums signed product beats up to tlast,
// then emits one rescaled, rounded and saturated result beat.
module axis_accumulator
    import axis_accumulator_pkg::*;
#(
    parameter int IN_WIDTH     = 31,
    parameter int ACC_WIDTH    = 40,
    parameter int OUT_WIDTH    = 16,
    parameter int SHIFT        = 0,
    parameter int ROUND_ENABLE = 1,
    parameter int ID_ENABLE    = 0,
    parameter int ID_WIDTH     = 8,
    parameter int DEST_ENABLE  = 0,
    parameter int DEST_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [ID_WIDTH-1:0]         s_axis_tid,
    input  logic [DEST_WIDTH-1:0]       s_axis_tdest,
    input  logic                        s_axis_tuser,
    output logic signed [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [ID_WIDTH-1:0]         m_axis_tid,
    output logic [DEST_WIDTH-1:0]       m_axis_tdest,
    output logic                        m_axis_tuser
);

    localparam int EXT_W = ACC_WIDTH - IN_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    acc_state_t                  state_r;
    acc_state_t                  state_next_s;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] acc_next_s;
    logic signed [ACC_WIDTH-1:0] sat_sum_s;
    logic signed [ACC_WIDTH:0]   in_ext_s;
    logic signed [ACC_WIDTH:0]   sum_ext_s;
    logic                        acc_sat_s;
    logic                        flag_r;
    logic                        flag_next_s;
    logic                        accept_s;
    logic                        emit_s;
    logic                        fresh_s;
    logic signed [OUT_WIDTH-1:0] res_s;
    logic                        out_sat_s;

    logic signed [OUT_WIDTH-1:0] m_data_r;
    logic                        m_valid_r;
    logic                        m_user_r;
    logic [ID_WIDTH-1:0]         m_id_r;
    logic [DEST_WIDTH-1:0]       m_dest_r;

    assign s_axis_tready = !m_valid_r || m_axis_tready;
    assign accept_s      = s_axis_tvalid && s_axis_tready;

    assign m_axis_tdata  = m_data_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tlast  = 1'b1;
    assign m_axis_tid    = m_id_r;
    assign m_axis_tdest  = m_dest_r;
    assign m_axis_tuser  = m_user_r;

    // Running sum at ACC_WIDTH+1 bits, clamped back into the accumulator range.
    always_comb begin
        in_ext_s  = {{EXT_W{s_axis_tdata[IN_WIDTH-1]}}, s_axis_tdata};
        sum_ext_s = {acc_r[ACC_WIDTH-1], acc_r} + in_ext_s;
        sat_sum_s = sum_ext_s[ACC_WIDTH-1:0];
        acc_sat_s = 1'b0;
        if (sum_ext_s[ACC_WIDTH] != sum_ext_s[ACC_WIDTH-1]) begin
            acc_sat_s = 1'b1;
            sat_sum_s = sum_ext_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sat_s = 1'b0;
            sat_sum_s = sum_ext_s[ACC_WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: a tlast beat always closes the packet.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !s_axis_tlast) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && s_axis_tlast) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the first beat of a packet replaces the sum instead of adding to it.
    always_comb begin
        emit_s      = accept_s && s_axis_tlast;
        fresh_s     = 1'b1;
        acc_next_s  = in_ext_s[ACC_WIDTH-1:0];
        flag_next_s = s_axis_tuser;
        case (state_r)
            ST_IDLE:  fresh_s = 1'b1;
            ST_ACCUM: fresh_s = 1'b0;
            default:  fresh_s = 1'b1;
        endcase
        if (fresh_s) begin
            acc_next_s  = in_ext_s[ACC_WIDTH-1:0];
            flag_next_s = s_axis_tuser;
        end else begin
            acc_next_s  = sat_sum_s;
            flag_next_s = flag_r | s_axis_tuser | acc_sat_s;
        end
    end

    // Accumulator and sticky flag, updated only on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= {ACC_WIDTH{1'b0}};
            flag_r <= 1'b0;
        end else if (accept_s) begin
            acc_r  <= acc_next_s;
            flag_r <= flag_next_s;
        end else begin
            acc_r  <= acc_r;
            flag_r <= flag_r;
        end
    end

    axis_accumulator_sat_round_shift #(
        .IN_W         (ACC_WIDTH),
        .OUT_W        (OUT_WIDTH),
        .SHIFT        (SHIFT),
        .ROUND_ENABLE (ROUND_ENABLE)
    ) u_sat_round_shift (
        .din  (acc_next_s),
        .dout (res_s),
        .sat  (out_sat_s)
    );

    // Result register: a new result may load in the same cycle the old one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {OUT_WIDTH{1'b0}};
            m_user_r  <= 1'b0;
            m_id_r    <= {ID_WIDTH{1'b0}};
            m_dest_r  <= {DEST_WIDTH{1'b0}};
        end else if (emit_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= res_s;
            m_user_r  <= flag_next_s | out_sat_s;
            m_id_r    <= (ID_ENABLE != 0) ? s_axis_tid : {ID_WIDTH{1'b0}};
            m_dest_r  <= (DEST_ENABLE != 0) ? s_axis_tdest : {DEST_WIDTH{1'b0}};
        end else if (m_axis_tready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

endmodule

// File: tb/tb_axis_accumulator.sv
// Self-checking bench: three accumulator configurations share one input stream
// and are checked against a packet-level arithmetic reference model.
module tb_axis_accumulator;

    localparam int NDUT = 3;
    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;
    localparam longint OUT_MAX = 64'sd32767;
    localparam longint OUT_MIN = -64'sd32768;

    typedef struct {
        longint     data;
        logic       user;
        logic [7:0] id;
        logic [7:0] dest;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] s_tdata = 16'sd0;
    logic               s_tvalid = 1'b0;
    logic               s_tlast = 1'b0;
    logic               s_tuser = 1'b0;
    logic [7:0]         s_tid = 8'd0;
    logic [7:0]         s_tdest = 8'd0;
    logic               m_tready = 1'b1;

    logic               s_tready [NDUT];
    logic signed [15:0] m_tdata  [NDUT];
    logic               m_tvalid [NDUT];
    logic               m_tlast  [NDUT];
    logic               m_tuser  [NDUT];
    logic [7:0]         m_tid    [NDUT];
    logic [7:0]         m_tdest  [NDUT];

    exp_t   exp_q [NDUT][$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     ready_mode = 0;
    longint mdl_sum = 0;
    logic   mdl_flag = 1'b0;
    logic   mdl_in_pkt = 1'b0;

    always #5 clk = ~clk;

    axis_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(0),
                       .ROUND_ENABLE(1), .ID_ENABLE(1), .ID_WIDTH(8),
                       .DEST_ENABLE(1), .DEST_WIDTH(8)) u_main (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[0]),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast[0]), .m_axis_tid(m_tid[0]), .m_axis_tdest(m_tdest[0]), .m_axis_tuser(m_tuser[0]));

    axis_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(4),
                       .ROUND_ENABLE(1), .ID_ENABLE(0), .ID_WIDTH(8),
                       .DEST_ENABLE(0), .DEST_WIDTH(8)) u_rnd (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[1]),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast[1]), .m_axis_tid(m_tid[1]), .m_axis_tdest(m_tdest[1]), .m_axis_tuser(m_tuser[1]));

    axis_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(4),
                       .ROUND_ENABLE(0), .ID_ENABLE(0), .ID_WIDTH(8),
                       .DEST_ENABLE(0), .DEST_WIDTH(8)) u_trn (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[2]),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast[2]), .m_axis_tid(m_tid[2]), .m_axis_tdest(m_tdest[2]), .m_axis_tuser(m_tuser[2]));

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Expected result of one packet for configuration k (0: shift 0, 1: shift 4 rounded, 2: shift 4 truncated).
    function automatic exp_t expect_for(input int k, input longint sum, input logic flag,
                                        input logic [7:0] id, input logic [7:0] dest);
        exp_t   e;
        int     sh;
        longint r;
        sh = (k == 0) ? 0 : 4;
        r  = sum;
        if (k == 1) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        e.user = flag;
        if (r > OUT_MAX) begin
            r = OUT_MAX;
            e.user = 1'b1;
        end else if (r < OUT_MIN) begin
            r = OUT_MIN;
            e.user = 1'b1;
        end
        e.data = r;
        e.id   = (k == 0) ? id : 8'd0;
        e.dest = (k == 0) ? dest : 8'd0;
        return e;
    endfunction

    task automatic model_accept(input longint d, input logic l, input logic u,
                                input logic [7:0] id, input logic [7:0] dest);
        longint s;
        if (!mdl_in_pkt) begin
            mdl_sum  = d;
            mdl_flag = u;
        end else begin
            s = mdl_sum + d;
            mdl_flag = mdl_flag | u;
            if (s > ACC_MAX) begin
                s = ACC_MAX;
                mdl_flag = 1'b1;
            end else if (s < ACC_MIN) begin
                s = ACC_MIN;
                mdl_flag = 1'b1;
            end
            mdl_sum = s;
        end
        mdl_in_pkt = !l;
        if (l) begin
            for (int k = 0; k < NDUT; k++) exp_q[k].push_back(expect_for(k, mdl_sum, mdl_flag, id, dest));
        end
    endtask

    // Offer one beat (called at a negedge); returns at the negedge after it is accepted.
    task automatic send_beat(input longint d, input logic l, input logic u = 1'b0);
        int w;
        w        = 0;
        s_tdata  = d[15:0];
        s_tlast  = l;
        s_tuser  = u;
        s_tid    = 8'($urandom_range(0, 255));
        s_tdest  = 8'($urandom_range(0, 255));
        s_tvalid = 1'b1;
        while (!s_tready[0] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!s_tready[0]) begin
            check_val("input_accept_timeout", s_tready[0], 1);
        end else begin
            model_accept(longint'(s_tdata), l, u, s_tid, s_tdest);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1;
        rst = 1'b1;
        s_tvalid = 1'b0;
        mdl_in_pkt = 1'b0;
        mdl_flag = 1'b0;
        mdl_sum = 0;
        for (int k = 0; k < NDUT; k++) exp_q[k].delete();
        repeat (cycles) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check_val("drain_pending", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    endtask

    // Downstream ready generator: always ready, stalled, or random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'b0;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: scoreboard every handshake, plus ready and stability rules.
    logic               prev_hold [NDUT];
    logic signed [15:0] prev_data [NDUT];
    logic               prev_user [NDUT];
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < NDUT; k++) begin
                check_val($sformatf("s_tready_rule[%0d]", k), s_tready[k], !m_tvalid[k] || m_tready);
                if (prev_hold[k]) begin
                    check_val($sformatf("held_valid[%0d]", k), m_tvalid[k], 1);
                    check_val($sformatf("held_data[%0d]", k), m_tdata[k], prev_data[k]);
                    check_val($sformatf("held_user[%0d]", k), m_tuser[k], prev_user[k]);
                end
                if (m_tvalid[k] && m_tready) begin
                    if (exp_q[k].size() == 0) begin
                        check_val($sformatf("unexpected_output[%0d]", k), m_tdata[k], 64'sh7fff_ffff);
                    end else begin
                        e = exp_q[k].pop_front();
                        check_val($sformatf("out_data[%0d]", k), m_tdata[k], e.data);
                        check_val($sformatf("out_user[%0d]", k), m_tuser[k], e.user);
                        check_val($sformatf("out_last[%0d]", k), m_tlast[k], 1);
                        check_val($sformatf("out_id[%0d]", k), m_tid[k], e.id);
                        check_val($sformatf("out_dest[%0d]", k), m_tdest[k], e.dest);
                    end
                end
                prev_hold[k] = m_tvalid[k] && !m_tready;
                prev_data[k] = m_tdata[k];
                prev_user[k] = m_tuser[k];
            end
        end else begin
            for (int k = 0; k < NDUT; k++) prev_hold[k] = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        do_reset(3);
        @(negedge clk);
        check_val("reset_tvalid", m_tvalid[0], 0);
        check_val("reset_tdata", m_tdata[0], 0);
        check_val("reset_tuser", m_tuser[0], 0);
        check_val("reset_tid", m_tid[0], 0);
        check_val("reset_tready", s_tready[0], 1);

        // Basic sum and one-cycle latency.
        send_beat(3, 1'b0);
        send_beat(5, 1'b0);
        send_beat(-2, 1'b1);
        check_val("basic_latency_valid", m_tvalid[0], 1);
        check_val("basic_sum", m_tdata[0], 6);
        check_val("basic_user", m_tuser[0], 0);
        drain();

        // Back-to-back packets: second must not include the first.
        send_beat(10, 1'b0);
        send_beat(20, 1'b1);
        check_val("b2b_first", m_tdata[0], 30);
        send_beat(-7, 1'b1);
        check_val("b2b_second", m_tdata[0], -7);
        check_val("b2b_second_valid", m_tvalid[0], 1);
        drain();

        // Accumulator saturation, then a clean packet.
        for (int i = 0; i < 600; i++) send_beat(32767, (i == 599));
        check_val("sat_data", m_tdata[0], 32767);
        check_val("sat_user", m_tuser[0], 1);
        send_beat(1, 1'b1);
        check_val("after_sat_data", m_tdata[0], 1);
        check_val("after_sat_user", m_tuser[0], 0);
        drain();

        // Rounding versus truncation at SHIFT=4.
        send_beat(24, 1'b1);
        check_val("round_pos", m_tdata[1], 2);
        check_val("trunc_pos", m_tdata[2], 1);
        send_beat(-24, 1'b1);
        check_val("round_neg", m_tdata[1], -1);
        check_val("trunc_neg", m_tdata[2], -2);
        drain();

        // Backpressure: second result waits, then streams with no bubble.
        ready_mode = 1;
        @(negedge clk);
        send_beat(1, 1'b0);
        send_beat(2, 1'b1);
        check_val("bp_tready_low", s_tready[0], 0);
        fork
            send_beat(3, 1'b1);
            begin
                repeat (5) @(negedge clk);
                check_val("bp_hold_data", m_tdata[0], 3);
                check_val("bp_hold_valid", m_tvalid[0], 1);
                ready_mode = 0;
            end
        join
        check_val("bp_no_bubble", m_tvalid[0], 1);
        check_val("bp_second_data", m_tdata[0], 3);
        drain();

        // Reset in the middle of a packet discards the partial sum.
        send_beat(100, 1'b0);
        send_beat(200, 1'b0);
        do_reset(1);
        @(negedge clk);
        check_val("midrst_tvalid", m_tvalid[0], 0);
        send_beat(1, 1'b0);
        send_beat(1, 1'b1);
        check_val("midrst_sum", m_tdata[0], 2);
        drain();

        // Randomised packets with random downstream stalls and input gaps.
        ready_mode = 2;
        for (int p = 0; p < 150; p++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                if (p % 5 == 0) begin
                    send_beat(longint'($urandom_range(30000, 32767)), (b == len - 1),
                              ($urandom_range(0, 15) == 0));
                end else begin
                    send_beat(longint'($urandom_range(0, 65535)) - 32768, (b == len - 1),
                              ($urandom_range(0, 15) == 0));
                end
            end
        end
        drain();
        ready_mode = 0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
